// File: rtl/cu_mod1_3.sv
// rtl/cu_mod1_3.sv - FFT stage butterfly control unit
//
// Sequences one FFT butterfly stage per frame of FRAME_LEN cycles. The frame is
// started by alert_mod12 from the previous stage. This unit drives the butterfly
// and multiplier enables, the twiddle ROM address and the delay-buffer half select.
//
// Optional feature macro: CU_MOD13_ABORT_DETECT_EN
//   defined   - alert_mod12 dropping mid-frame truncates the frame through a
//               one-cycle ABORT state that pulses err_abort.
//   undefined - a started frame always runs to FRAME_LEN cycles and err_abort is 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rstn         in   asynchronous active-low reset
//   alert_mod12  in   previous-stage level, high one cycle ahead of each sample
//   bf_en        out  butterfly enable (high while the FSM is in RUN)
//   mul_en       out  twiddle multiplier enable (bf_en delayed one cycle)
//   tw_addr[8:0] out  twiddle ROM address, (cnt*TW_STEP) mod 512 while bf_en is high
//   sr_sel       out  delay-buffer half select (second half of the frame)
//   frame_done   out  one-cycle pulse after the last cycle of a full frame
//   err_abort    out  one-cycle pulse on a truncated frame
//   alert_mod13  out  level to the next stage (bf_en delayed one cycle)

module cu_mod1_3 #(
  parameter int FRAME_LEN = 32,
  parameter int TW_STEP   = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       alert_mod12,
  output logic       bf_en,
  output logic       mul_en,
  output logic [8:0] tw_addr,
  output logic       sr_sel,
  output logic       frame_done,
  output logic       err_abort,
  output logic       alert_mod13
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

`ifdef CU_MOD13_ABORT_DETECT_EN
  typedef enum logic [1:0] {IDLE, RUN, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mul_en_q, mul_en_d;
  logic            frame_done_q, frame_done_d;
  logic [8:0]      tw_raw;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_en_d     = (state_q == RUN);
    frame_done_d = (state_q == RUN) && (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (alert_mod12) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          // A still-high alert at the frame end chains the next frame with no bubble.
          if (alert_mod12) cnt_d = '0;
          else             state_d = IDLE;
        end else begin
`ifdef CU_MOD13_ABORT_DETECT_EN
          if (alert_mod12) cnt_d = cnt_q + CW'(1);
          else             state_d = ABORT;
`else
          // The frame is padded to full length even if the alert drops.
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
`ifdef CU_MOD13_ABORT_DETECT_EN
      ABORT: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mul_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_en_q     <= mul_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The 9-bit product wraps modulo 512, which matches the twiddle ROM depth.
  assign tw_raw = 9'(cnt_q) * 9'(TW_STEP);

  // All outputs are decoded from flops, so there is no path from alert_mod12.
  assign bf_en       = (state_q == RUN);
  assign tw_addr     = bf_en ? tw_raw : 9'd0;
  assign sr_sel      = bf_en & cnt_q[CW-1];
  assign mul_en      = mul_en_q;
  assign alert_mod13 = mul_en_q;
  assign frame_done  = frame_done_q;
`ifdef CU_MOD13_ABORT_DETECT_EN
  assign err_abort   = (state_q == ABORT);
`else
  assign err_abort   = 1'b0;
`endif

endmodule

// File: tb/tb_cu_mod1_3.sv
// tb/tb_cu_mod1_3.sv - self-checking bench for cu_mod1_3

module tb_cu_mod1_3;

  localparam int L  = 32;
  localparam int TW = 16;
`ifdef CU_MOD13_ABORT_DETECT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       alert;
  logic       bf_en, mul_en, sr_sel, frame_done, err_abort, alert_mod13;
  logic [8:0] tw_addr;

  cu_mod1_3 #(.FRAME_LEN(L), .TW_STEP(TW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .alert_mod12(alert),
    .bf_en      (bf_en),
    .mul_en     (mul_en),
    .tw_addr    (tw_addr),
    .sr_sel     (sr_sel),
    .frame_done (frame_done),
    .err_abort  (err_abort),
    .alert_mod13(alert_mod13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_bf, n_fd, n_err;

  // Reference model: 0 idle, 1 run, 2 abort.
  int m_state = 0;
  int m_cnt   = 0;
  logic [14:0] sb_q[$];

  typedef struct {
    int hi;
    int exp_bf;
    int exp_fd;
    int exp_err;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [14:0] dut_vec();
    return {bf_en, mul_en, alert_mod13, sr_sel, frame_done, err_abort, tw_addr};
  endfunction

  task automatic check_vec(input string name, input logic [14:0] got, input logic [14:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got bf/mul/a13/sr/fd/err/tw=%b/%b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%b/%0d",
               name, $time, got[14], got[13], got[12], got[11], got[10], got[9], got[8:0],
               exp[14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[8:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One clock cycle: compare the previous cycle's outputs, drive new inputs,
  // advance the model and queue what the DUT must show next cycle.
  task automatic step(input logic r, input logic a);
    logic [14:0] exp, got;
    bit pbf;
    int pcnt, tw;
    @(negedge clk);
    got = dut_vec();
    if (bf_en)      n_bf++;
    if (frame_done) n_fd++;
    if (err_abort)  n_err++;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check_vec("cycle", got, exp);
    end
    rstn  = r;
    alert = a;
    if (!r) begin
      #1;
      check_vec("reset_zero", dut_vec(), 15'd0);
      m_state = 0;
      m_cnt   = 0;
      sb_q.delete();
      sb_q.push_back(15'd0);
    end else begin
      pbf  = (m_state == 1);
      pcnt = m_cnt;
      case (m_state)
        0: if (a) begin m_state = 1; m_cnt = 0; end
        1: begin
          if (m_cnt == L - 1) begin
            if (a) m_cnt = 0;
            else   m_state = 0;
          end else if (ABORT_EN && !a) begin
            m_state = 2;
          end else begin
            m_cnt++;
          end
        end
        default: m_state = 0;
      endcase
      tw  = (m_state == 1) ? (m_cnt * TW) % 512 : 0;
      exp = {(m_state == 1), pbf, pbf, (m_state == 1) && (m_cnt >= L / 2),
             pbf && (pcnt == L - 1), (m_state == 2), 9'(tw)};
      sb_q.push_back(exp);
    end
  endtask

  initial begin
    rstn  = 1'b0;
    alert = 1'b0;
    n_bf = 0; n_fd = 0; n_err = 0;

    vecs[0] = '{hi: 32, exp_bf: 32, exp_fd: 1, exp_err: 0};
    vecs[1] = '{hi: 64, exp_bf: 64, exp_fd: 2, exp_err: 0};
    vecs[2] = ABORT_EN ? '{hi: 10, exp_bf: 10, exp_fd: 0, exp_err: 1}
                       : '{hi: 10, exp_bf: 32, exp_fd: 1, exp_err: 0};
    vecs[3] = ABORT_EN ? '{hi: 33, exp_bf: 33, exp_fd: 1, exp_err: 1}
                       : '{hi: 33, exp_bf: 64, exp_fd: 2, exp_err: 0};
    vecs[4] = ABORT_EN ? '{hi: 1,  exp_bf: 1,  exp_fd: 0, exp_err: 1}
                       : '{hi: 1,  exp_bf: 32, exp_fd: 1, exp_err: 0};

    repeat (3) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      n_bf = 0; n_fd = 0; n_err = 0;
      repeat (vecs[i].hi) step(1'b1, 1'b1);
      repeat (40) step(1'b1, 1'b0);
      check_int($sformatf("vec%0d_bf_cycles", i), n_bf, vecs[i].exp_bf);
      check_int($sformatf("vec%0d_frame_done", i), n_fd, vecs[i].exp_fd);
      check_int($sformatf("vec%0d_err_abort", i), n_err, vecs[i].exp_err);
    end

    // Reset during the cnt=20 cycle, released with the alert already high.
    n_bf = 0; n_fd = 0; n_err = 0;
    repeat (21) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    repeat (32) step(1'b1, 1'b1);
    repeat (40) step(1'b1, 1'b0);
    check_int("rst_bf_cycles", n_bf, 53);
    check_int("rst_frame_done", n_fd, 1);
    check_int("rst_err_abort", n_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cu_mod1_3.md
CU_MOD1_3 -- requirements
Module: cu_mod1_3

Interface
REQ-001 Parameter FRAME_LEN, 32, butterfly cycles per frame; power of two, 4..512.
REQ-002 Parameter TW_STEP, 16, twiddle-address increment per butterfly cycle.
REQ-003 Port clk  input  1  clock; all state changes on its rising edge.
REQ-004 Port rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port alert_mod12  input  1  level from the previous control stage; high one cycle ahead of each valid sample.
REQ-006 Port bf_en  output  1  butterfly enable for this stage.
REQ-007 Port mul_en  output  1  twiddle multiplier enable.
REQ-008 Port tw_addr  output  9  twiddle ROM address.
REQ-009 Port sr_sel  output  1  delay-buffer half select: 0 for first half of frame, 1 for second.
REQ-010 Port frame_done  output  1  one-cycle pulse per completed frame.
REQ-011 Port err_abort  output  1  one-cycle pulse on a truncated frame.
REQ-012 Port alert_mod13  output  1  level to the next control stage.

Function
REQ-013 FSM states SHALL be IDLE, RUN and ABORT; all outputs registered or decoded from registers, no combinational path from alert_mod12.
REQ-014 IDLE -> RUN when alert_mod12 sampled high; cycle counter cnt loads 0.
REQ-015 bf_en SHALL be high exactly in cycles where state is RUN: first bf_en one cycle after alert_mod12 rises.
REQ-016 In RUN, cnt SHALL increment by 1 per cycle, range 0..FRAME_LEN-1.
REQ-017 RUN with cnt = FRAME_LEN-1 and alert_mod12 high: stay RUN, cnt wraps to 0 (back-to-back frames, no bubble).
REQ-018 RUN with cnt = FRAME_LEN-1 and alert_mod12 low: go IDLE.
REQ-019 RUN with cnt < FRAME_LEN-1 and alert_mod12 low: go ABORT.
REQ-020 ABORT SHALL last exactly one cycle, then IDLE regardless of alert_mod12; err_abort high during that cycle; bf_en low.
REQ-021 tw_addr SHALL equal (cnt*TW_STEP) mod 512 in every bf_en cycle, and 0 when bf_en low; wrap is modulo 2^9, no saturation.
REQ-022 sr_sel SHALL equal cnt MSB (cnt >= FRAME_LEN/2) while bf_en high; 0 otherwise.
REQ-023 mul_en SHALL be bf_en delayed by one cycle.
REQ-024 alert_mod13 SHALL be bf_en delayed by one cycle (identical timing to mul_en).
REQ-025 frame_done SHALL pulse in the cycle after a bf_en cycle with cnt = FRAME_LEN-1; never after an aborted frame.
REQ-026 Back-to-back frames: frame_done pulses once per frame while bf_en stays continuously high.

Reset
REQ-027 rstn low SHALL immediately force state IDLE, cnt 0 and every output to 0.
REQ-028 Reset mid-frame SHALL discard the frame: no frame_done, no err_abort; after release a new frame starts only on alert_mod12 high.
REQ-029 alert_mod12 high during reset release SHALL start a frame on the first clock edge after rstn rises.

Configuration
REQ-030 Macro CU_MOD13_ABORT_DETECT_EN defined: ABORT state and err_abort behave per REQ-019/020.
REQ-031 Macro undefined: no ABORT state; RUN with cnt < FRAME_LEN-1 SHALL continue to FRAME_LEN-1 regardless of alert_mod12 (frame padded to full length, frame_done still pulses); err_abort tied to 0.

Verification
REQ-032 Reset, then alert_mod12 high 32 cycles -> bf_en high 32 cycles starting 1 cycle later, tw_addr 0,16,...,496, sr_sel 1 from cnt 16, frame_done one pulse, err_abort 0.
REQ-033 alert_mod12 high 64 cycles -> bf_en high 64 continuous cycles, tw_addr wraps 496 -> 0 with no gap, two frame_done pulses 32 cycles apart.
REQ-034 alert_mod12 high 10 cycles then low (macro defined) -> bf_en 10 cycles, err_abort one pulse in following cycle, no frame_done, tw_addr 0 afterwards.
REQ-035 Same stimulus, macro undefined -> bf_en 32 cycles, frame_done one pulse, err_abort never high.
REQ-036 rstn low at cnt 20 -> all outputs 0 same cycle; after release with alert_mod12 high, cnt restarts at 0 (tw_addr 0).
REQ-037 Any run -> mul_en and alert_mod13 equal bf_en delayed exactly one cycle, checked every cycle.
